butterfly_unit: RTL and testbench

//  Radix-2 decimation-in-time FFT butterfly for a 32-point complex FFT datapath.
//  - Computes A = a + W*b and B = a - W*b, with W = W32^k = cos(2*pi*k/32) - j*sin(2*pi*k/32).
//  - k is twiddle_num; the twiddle table is an internal ROM.
//  - Fully pipelined: accepts one butterfly every clock.
//  - Sits between the FFT stage memories and the address/twiddle sequencer.

---
 rtl/butterfly_unit.sv | 138 +++++++++++++
 tb/tb_butterfly_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/butterfly_unit.sv
// butterfly_unit: pipelined radix-2 DIT butterfly for a 32-point complex FFT.
//   A = a + W*b, B = a - W*b, W = W32^k taken from an internal 16-entry ROM.
//   Two register stages: twiddle multiply + rounding, then add/subtract + reduce.
//   Optional build macro BUTTERFLY_SAT_EN: saturate results instead of wrapping.
module butterfly_unit #(
    parameter int data_size = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [data_size:0]   i_data_ra,
    input  logic [data_size:0]   i_data_ca,
    input  logic [data_size:0]   i_data_rb,
    input  logic [data_size:0]   i_data_cb,
    input  logic [3:0]           twiddle_num,
    output logic [data_size:0]   o_data_ra,
    output logic [data_size:0]   o_data_ca,
    output logic [data_size:0]   o_data_rb,
    output logic [data_size:0]   o_data_cb
);

    localparam int W  = data_size + 1;   // data word width
    localparam int SW = data_size + 3;   // width of W*b and of the stage-2 sums
    localparam int PW = 2 * W + 1;       // full complex-product width

`ifdef BUTTERFLY_SAT_EN
    localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** data_size) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = -SW'(2 ** data_size);
`endif

    logic signed [15:0]   wr, wi;
    logic signed [W-1:0]  ra_s, ca_s, rb_s, cb_s;
    logic signed [PW-1:0] prod_r, prod_i, rnd_r, rnd_i;

    logic signed [W-1:0]  ar_d, ai_d, ar_q, ai_q;
    logic signed [SW-1:0] wbr_d, wbi_d, wbr_q, wbi_q;
    logic signed [SW-1:0] sum [4];
    logic [W-1:0]         out_d [4];
    logic [W-1:0]         out_q [4];

    assign ra_s = $signed(i_data_ra);
    assign ca_s = $signed(i_data_ca);
    assign rb_s = $signed(i_data_rb);
    assign cb_s = $signed(i_data_cb);

    // Twiddle ROM: Q2.14 cos / -sin of 2*pi*k/32, rounded to nearest.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        wr = 16'sd0;
        wi = 16'sd0;
        case (twiddle_num)
            4'd0:  begin wr =  16'sd16384; wi =  16'sd0;     end
            4'd1:  begin wr =  16'sd16069; wi = -16'sd3196;  end
            4'd2:  begin wr =  16'sd15137; wi = -16'sd6270;  end
            4'd3:  begin wr =  16'sd13623; wi = -16'sd9102;  end
            4'd4:  begin wr =  16'sd11585; wi = -16'sd11585; end
            4'd5:  begin wr =  16'sd9102;  wi = -16'sd13623; end
            4'd6:  begin wr =  16'sd6270;  wi = -16'sd15137; end
            4'd7:  begin wr =  16'sd3196;  wi = -16'sd16069; end
            4'd8:  begin wr =  16'sd0;     wi = -16'sd16384; end
            4'd9:  begin wr = -16'sd3196;  wi = -16'sd16069; end
            4'd10: begin wr = -16'sd6270;  wi = -16'sd15137; end
            4'd11: begin wr = -16'sd9102;  wi = -16'sd13623; end
            4'd12: begin wr = -16'sd11585; wi = -16'sd11585; end
            4'd13: begin wr = -16'sd13623; wi = -16'sd9102;  end
            4'd14: begin wr = -16'sd15137; wi = -16'sd6270;  end
            4'd15: begin wr = -16'sd16069; wi = -16'sd3196;  end
            default: begin wr = 16'sd0;    wi = 16'sd0;      end
        endcase
    end

    // Stage-1 next state: complex multiply W*b, round half up to Q0, pass a along.
    always_comb begin
        prod_r = PW'(rb_s) * PW'(wr) - PW'(cb_s) * PW'(wi);
        prod_i = PW'(rb_s) * PW'(wi) + PW'(cb_s) * PW'(wr);
        rnd_r  = prod_r + PW'(8192);
        rnd_i  = prod_i + PW'(8192);
        wbr_d  = SW'(rnd_r >>> 14);
        wbi_d  = SW'(rnd_i >>> 14);
        ar_d   = ra_s;
        ai_d   = ca_s;
    end

    // Stage-1 registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            ar_q  <= '0;
            ai_q  <= '0;
            wbr_q <= '0;
            wbi_q <= '0;
        end else begin
            ar_q  <= ar_d;
            ai_q  <= ai_d;
            wbr_q <= wbr_d;
            wbi_q <= wbi_d;
        end
    end

    // Stage-2 next state: butterfly sums at full width, then reduce to W bits.
    always_comb begin
        sum[0] = SW'(ar_q) + wbr_q;
        sum[1] = SW'(ai_q) + wbi_q;
        sum[2] = SW'(ar_q) - wbr_q;
        sum[3] = SW'(ai_q) - wbi_q;
        for (int i = 0; i < 4; i++) begin
`ifdef BUTTERFLY_SAT_EN
            if (sum[i] > SAT_MAX)
                out_d[i] = SAT_MAX[W-1:0];
            else if (sum[i] < SAT_MIN)
                out_d[i] = SAT_MIN[W-1:0];
            else
                out_d[i] = sum[i][W-1:0];
`else
            out_d[i] = sum[i][W-1:0];
`endif
        end
    end

    // Output registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) out_q[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) out_q[i] <= out_d[i];
        end
    end

    assign o_data_ra = out_q[0];
    assign o_data_ca = out_q[1];
    assign o_data_rb = out_q[2];
    assign o_data_cb = out_q[3];

    // Bits dropped by the rounding shift and, in the wrap build, the sum guard bits.
    logic unused_bits;
    assign unused_bits = ^{rnd_r[13:0], rnd_r[PW-1:SW+14], rnd_i[13:0], rnd_i[PW-1:SW+14],
                           sum[0][SW-1:W], sum[1][SW-1:W], sum[2][SW-1:W], sum[3][SW-1:W]};

endmodule

// File: tb/tb_butterfly_unit.sv
// Testbench for butterfly_unit: directed vectors, scoreboard queue, negedge monitor.
module tb_butterfly_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ra, ca, rb, cb;
    logic [3:0]  k;
    logic [15:0] o_ra, o_ca, o_rb, o_cb;

    typedef struct {
        string       name;
        logic [63:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    logic       vld_in;
    logic [1:0] vld_pipe;

    butterfly_unit #(.data_size(15)) dut (
        .clk(clk), .rst(rst),
        .i_data_ra(ra), .i_data_ca(ca), .i_data_rb(rb), .i_data_cb(cb),
        .twiddle_num(k),
        .o_data_ra(o_ra), .o_data_ca(o_ca), .o_data_rb(o_rb), .o_data_cb(o_cb)
    );

    always #5 clk = ~clk;

    // Tracks which output cycles carry a result of an issued vector (2-cycle latency).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_pipe <= 2'b00;
        else     vld_pipe <= {vld_pipe[0], vld_in};
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got A=(%h,%h) B=(%h,%h) expected A=(%h,%h) B=(%h,%h)", name,
                     act[63:48], act[47:32], act[31:16], act[15:0],
                     exp[63:48], exp[47:32], exp[31:16], exp[15:0]);
        end
    endtask

    // Monitor: compare every presented result against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && vld_pipe[1]) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard: output %h with no expected entry", {o_ra, o_ca, o_rb, o_cb});
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.name, {o_ra, o_ca, o_rb, o_cb}, e.v);
            end
        end
    end

    // Drive one butterfly for one cycle and record its expected outputs.
    task automatic issue(input string name, input logic [15:0] ar, ai, br, bi, input logic [3:0] kk,
                         input logic [15:0] xr, xi, yr, yi);
        exp_t e;
        ra = ar; ca = ai; rb = br; cb = bi; k = kk;
        vld_in = 1'b1;
        e.name = name;
        e.v    = {xr, xi, yr, yi};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            ra = '0; ca = '0; rb = '0; cb = '0; k = '0;
            vld_in = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; vld_in = 1'b0;
        ra = '0; ca = '0; rb = '0; cb = '0; k = '0;
        #1;
        check("reset_initial", {o_ra, o_ca, o_rb, o_cb}, 64'h0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // Zero inputs right after release give zero outputs.
        issue("zero_0", 16'h0, 16'h0, 16'h0, 16'h0, 4'd0, 16'h0, 16'h0, 16'h0, 16'h0);
        issue("zero_1", 16'h0, 16'h0, 16'h0, 16'h0, 4'd0, 16'h0, 16'h0, 16'h0, 16'h0);
        idle(3);

        // Single isolated vector.
        issue("k0_basic", 16'h0002, 16'h0004, 16'hFFFB, 16'h0023, 4'd0,
              16'hFFFD, 16'h0027, 16'h0007, 16'hFFE1);
        idle(3);

        // Back-to-back stream.
        issue("k0_b2b_a", 16'h0002, 16'h0004, 16'hFFFB, 16'h0023, 4'd0,
              16'hFFFD, 16'h0027, 16'h0007, 16'hFFE1);
        issue("k0_b2b_b", 16'h0064, 16'h0046, 16'hFF38, 16'h0023, 4'd0,
              16'hFF9C, 16'h0069, 16'h012C, 16'h0023);
        issue("k8_real", 16'h0000, 16'h0000, 16'h0064, 16'h0000, 4'd8,
              16'h0000, 16'hFF9C, 16'h0000, 16'h0064);
        issue("k4_1000", 16'h0000, 16'h0000, 16'h03E8, 16'h0000, 4'd4,
              16'h02C3, 16'hFD3D, 16'hFD3D, 16'h02C3);
        issue("k12_1000", 16'h0000, 16'h0000, 16'h03E8, 16'h0000, 4'd12,
              16'hFD3D, 16'hFD3D, 16'h02C3, 16'h02C3);
        issue("k8_imag", 16'h0000, 16'h0000, 16'h0000, 16'h0064, 4'd8,
              16'h0064, 16'h0000, 16'hFF9C, 16'h0000);
`ifdef BUTTERFLY_SAT_EN
        issue("pos_limit", 16'h7FFF, 16'h0000, 16'h0001, 16'h0000, 4'd0,
              16'h7FFF, 16'h0000, 16'h7FFE, 16'h0000);
        issue("neg_limit", 16'h8000, 16'h0000, 16'h0001, 16'h0000, 4'd0,
              16'h8001, 16'h0000, 16'h8000, 16'h0000);
`else
        issue("pos_limit", 16'h7FFF, 16'h0000, 16'h0001, 16'h0000, 4'd0,
              16'h8000, 16'h0000, 16'h7FFE, 16'h0000);
        issue("neg_limit", 16'h8000, 16'h0000, 16'h0001, 16'h0000, 4'd0,
              16'h8001, 16'h0000, 16'h7FFF, 16'h0000);
`endif
        idle(3);

        // Mid-stream asynchronous reset flushes in-flight data.
        issue("flushed_0", 16'h0002, 16'h0004, 16'hFFFB, 16'h0023, 4'd0,
              16'hFFFD, 16'h0027, 16'h0007, 16'hFFE1);
        issue("flushed_1", 16'h0064, 16'h0046, 16'hFF38, 16'h0023, 4'd0,
              16'hFF9C, 16'h0069, 16'h012C, 16'h0023);
        #2 rst = 1'b1;
        #1;
        check("reset_async", {o_ra, o_ca, o_rb, o_cb}, 64'h0);
        exp_q.delete();
        vld_in = 1'b0;
        ra = '0; ca = '0; rb = '0; cb = '0; k = '0;
        @(posedge clk);
        #1;
        check("reset_held_edge", {o_ra, o_ca, o_rb, o_cb}, 64'h0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        issue("post_rst_0", 16'h0, 16'h0, 16'h0, 16'h0, 4'd0, 16'h0, 16'h0, 16'h0, 16'h0);
        issue("post_rst_1", 16'h0, 16'h0, 16'h0, 16'h0, 4'd0, 16'h0, 16'h0, 16'h0, 16'h0);
        issue("post_rst_run", 16'h0064, 16'h0046, 16'hFF38, 16'h0023, 4'd0,
              16'hFF9C, 16'h0069, 16'h012C, 16'h0023);
        idle(1);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expected results never appeared, required 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
